jam_cost_table: RTL and testbench
=================================

Name: jam_cost_table

Overview:
- Upstream cost store for the job-assignment search engine.
- Accepts a streamed N×N cost matrix (row = worker, column = job) over a valid/ready interface and holds it in a register file.
- Serves the engine's combinational (W,J)→Cost lookups.
- Raises Table_Ready when a complete matrix is loaded, together with a LowerBound (sum of per-worker row minima) for result sanity checks.

Parameters:
- N, 8, matrix dimension (workers = jobs); power of two, 2..8; LOG2N = clog2(N) derived.
- COST_W, 7, bits per cost entry.
- LB_W, 10, LowerBound width; must hold N*(2^COST_W-1).

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  synchronous active-low reset
- Load_Start  input  1  one-cycle pulse; begins or restarts a matrix load
- In_Valid  input  1  In_Data holds a cost entry
- In_Ready  output  1  block accepts an entry this cycle
- In_Data  input  COST_W  cost entry, row-major order (W0J0, W0J1, …, W(N-1)J(N-1))
- W  input  LOG2N  lookup worker index
- J  input  LOG2N  lookup job index
- Cost  output  COST_W  mem[W*N+J], combinational
- Table_Ready  output  1  full matrix loaded and stable
- LowerBound  output  LB_W  sum over rows of min(row); valid when Table_Ready=1
- Load_Count  output  2*LOG2N+1  entries accepted in current load (0..N*N)

Behaviour:
- Reset is synchronous: RST_N sampled low at a CLK edge sets state=IDLE, In_Ready=0, Table_Ready=0, LowerBound=0, Load_Count=0, row-min register=all-ones.
- Matrix storage is not reset. Cost is don't-care until the first Table_Ready.
- FSM states:
  - IDLE: In_Ready=0. Load_Start → LOAD.
  - LOAD: In_Ready=1. Accepts entries. Transition to READY on the N*N-th transfer.
  - READY: In_Ready=0, Table_Ready=1. Load_Start → LOAD.
- Entering LOAD (at the edge sampling Load_Start) sets Load_Count=0, LowerBound=0, Table_Ready=0, In_Ready=1. These take effect the next cycle.
- Load_Start while in LOAD restarts the load. Counter and LowerBound clear; already-written entries remain but will be overwritten. A transfer in the same cycle as Load_Start is discarded.
- Transfer occurs when In_Valid=1 and In_Ready=1 at a CLK edge:
  - mem[Load_Count] <= In_Data; Load_Count += 1.
  - Row index = Load_Count[2*LOG2N-1:LOG2N]; column = Load_Count[LOG2N-1:0].
- Row minimum:
  - Column 0: rowmin <= In_Data.
  - Other columns: rowmin <= min(rowmin, In_Data), unsigned compare.
  - Column N-1: LowerBound <= LowerBound + min(rowmin, In_Data), zero-extended to LB_W. No overflow is possible with legal parameters.
- Final transfer (Load_Count == N*N-1): at that edge, state becomes READY, In_Ready=0, Table_Ready=1, Load_Count=N*N. LowerBound includes the last row in the same edge.
- Latency: Table_Ready is first high in the cycle after the last transfer edge.
- In_Valid while In_Ready=0 is ignored; no data loss is signalled. The producer must hold data until ready per standard valid/ready rules.
- In_Valid may drop mid-load. The load pauses with no timeout.
- Cost is purely combinational from W, J and storage. It changes in the same cycle W/J change, so it is usable on the engine's falling-edge accumulate.
- A write followed by a read of the same address returns the new value after the write edge.
- Lookups during LOAD return current (partially updated) contents. The consumer must gate on Table_Ready.
- Reset mid-load aborts: state IDLE, Table_Ready=0, storage retains partial contents.

Test Plan:
- Reset, then Load_Start and 64 entries In_Data=(i*5+3)%128, In_Valid held high:
  - In_Ready high for exactly 64 cycles.
  - Table_Ready rises the cycle after the 64th transfer; Load_Count=64.
  - Sweeping all W,J gives Cost=((8W+J)*5+3)%128.
- Row r = {r+10, 90, 90, 90, 90, 90, 90, 90} for r=0..7 → LowerBound = 10+11+…+17 = 108.
- All entries 127 → LowerBound=1016, no wrap. All entries 0 → LowerBound=0.
- Randomly toggled In_Valid (≈50%) with a matrix of known costs → contents and LowerBound match the ungated case; no entry is skipped or duplicated.
- Load_Start pulsed after 20 transfers, then a fresh 64-entry matrix:
  - Load_Count restarts at 0.
  - Final contents and LowerBound reflect only the second stream.
  - The entry presented alongside Load_Start is not written.
- Load complete, then RST_N low for one cycle → Table_Ready=0, In_Ready=0, LowerBound=0.
- In READY, In_Valid=1 with data 0x55 → no write, Load_Count stays 64.
- Reload with Load_Start from READY → Table_Ready drops the next cycle.

Source files
------------

// File: rtl/jam_cost_table.sv
// jam_cost_table: cost matrix store for the job-assignment search engine.
// Loads an N x N cost matrix row-major over valid/ready, serves combinational
// (W,J) -> Cost lookups and reports the sum of per-worker row minima.
module jam_cost_table #(
  parameter int N      = 8,
  parameter int COST_W = 7,
  parameter int LB_W   = 10,
  parameter int LOG2N  = $clog2(N)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 Load_Start,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  input  logic [COST_W-1:0]    In_Data,
  input  logic [LOG2N-1:0]     W,
  input  logic [LOG2N-1:0]     J,
  output logic [COST_W-1:0]    Cost,
  output logic                 Table_Ready,
  output logic [LB_W-1:0]      LowerBound,
  output logic [2*LOG2N:0]     Load_Count
);

  localparam int CNT_W = 2*LOG2N + 1;
  localparam int DEPTH = N * N;

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [COST_W-1:0]   mem [DEPTH];
  logic [COST_W-1:0]   rowmin;
  logic [COST_W-1:0]   new_min;
  logic [LOG2N-1:0]    col;
  logic                xfer;
  logic                last_xfer;

  function automatic logic [COST_W-1:0] min_u(input logic [COST_W-1:0] a,
                                              input logic [COST_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // A transfer that coincides with Load_Start is dropped: the load restarts.
  assign xfer      = In_Valid && In_Ready && !Load_Start;
  assign last_xfer = xfer && (Load_Count == CNT_W'(DEPTH - 1));
  assign col       = Load_Count[LOG2N-1:0];
  assign new_min   = min_u(rowmin, In_Data);

  // Lookup is a plain mux off the storage, usable in the same cycle W/J move.
  assign Cost = mem[{W, J}];

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    state_nxt   = state;
    In_Ready    = 1'b0;
    Table_Ready = 1'b0;
    case (state)
      IDLE: begin
        if (Load_Start) state_nxt = LOAD;
      end
      LOAD: begin
        In_Ready = 1'b1;
        if (Load_Start)     state_nxt = LOAD;
        else if (last_xfer) state_nxt = READY;
      end
      READY: begin
        Table_Ready = 1'b1;
        if (Load_Start) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Load counter, running row minimum and lower-bound accumulator.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      Load_Count <= '0;
      LowerBound <= '0;
      rowmin     <= '1;
    end else if (Load_Start) begin
      Load_Count <= '0;
      LowerBound <= '0;
    end else if (xfer) begin
      Load_Count <= Load_Count + CNT_W'(1);
      if (col == '0) rowmin <= In_Data;
      else           rowmin <= new_min;
      if (col == LOG2N'(N - 1))
        LowerBound <= LowerBound + LB_W'(new_min);
    end
  end

  // Matrix storage; deliberately not reset so partial contents survive aborts.
  always_ff @(posedge CLK) begin
    if (xfer) mem[Load_Count[2*LOG2N-1:0]] <= In_Data;
  end

endmodule

// File: tb/tb_jam_cost_table.sv
// Testbench for jam_cost_table: table-driven matrix loads plus hand-written
// restart, reset-abort, ignored-write and reload sequences.
module tb_jam_cost_table;

  logic        CLK;
  logic        RST_N;
  logic        Load_Start;
  logic        In_Valid;
  logic        In_Ready;
  logic [6:0]  In_Data;
  logic [2:0]  W;
  logic [2:0]  J;
  logic [6:0]  Cost;
  logic        Table_Ready;
  logic [9:0]  LowerBound;
  logic [6:0]  Load_Count;

  jam_cost_table #(.N(8), .COST_W(7), .LB_W(10)) dut (
    .CLK(CLK), .RST_N(RST_N), .Load_Start(Load_Start), .In_Valid(In_Valid),
    .In_Ready(In_Ready), .In_Data(In_Data), .W(W), .J(J), .Cost(Cost),
    .Table_Ready(Table_Ready), .LowerBound(LowerBound), .Load_Count(Load_Count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int ready_cycles;
  bit tr_early;
  logic [6:0] mat  [64];
  logic [6:0] prev [64];

  typedef struct {
    int pat;
    int pct;
    int exp_lb;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference: sum over workers of the smallest cost in that worker's row.
  function automatic int model_lb();
    int s = 0;
    for (int r = 0; r < 8; r++) begin
      int m = 1000;
      for (int c = 0; c < 8; c++)
        if (int'(mat[r*8+c]) < m) m = int'(mat[r*8+c]);
      s += m;
    end
    return s;
  endfunction

  task automatic fill(input int pat);
    for (int i = 0; i < 64; i++) begin
      case (pat)
        0: mat[i] = 7'((i*5 + 3) % 128);
        1: mat[i] = (i % 8 == 0) ? 7'(i/8 + 10) : 7'd90;
        2: mat[i] = 7'd127;
        3: mat[i] = 7'd0;
        default: mat[i] = 7'($urandom_range(0, 127));
      endcase
    end
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    Load_Start = 1'b1;
    In_Valid   = 1'b0;
    @(negedge CLK);
    Load_Start = 1'b0;
  endtask

  // Present mat[0..n-1] in order, In_Valid high with probability pct%.
  task automatic feed(input int pct, input int n);
    int   i;
    int   cyc;
    logic rdy;
    i = 0;
    cyc = 0;
    ready_cycles = 0;
    tr_early = 1'b0;
    while (i < n && cyc < 3000) begin
      In_Valid = ($urandom_range(0, 99) < pct);
      In_Data  = mat[i];
      rdy = In_Ready;
      if (rdy) ready_cycles++;
      if (Table_Ready) tr_early = 1'b1;
      @(negedge CLK);
      cyc++;
      if (In_Valid && rdy) i++;
    end
    In_Valid = 1'b0;
    if (i < n) chk("feed_timeout", i, n);
  endtask

  task automatic sweep(input string nm);
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++) begin
        W = 3'(w);
        J = 3'(j);
        #1;
        chk(nm, int'(Cost), int'(mat[w*8+j]));
      end
  endtask

  task automatic check_done(input int exp_lb);
    chk("load_count_full", int'(Load_Count), 64);
    chk("table_ready", int'(Table_Ready), 1);
    chk("in_ready_low", int'(In_Ready), 0);
    chk("tr_before_last", int'(tr_early), 0);
    chk("lower_bound", int'(LowerBound), exp_lb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 100, 268};
    tbl[1] = '{1, 100, 108};
    tbl[2] = '{2, 100, 1016};
    tbl[3] = '{4, 50, -1};
    tbl[4] = '{0, 50, 268};
    tbl[5] = '{3, 100, 0};

    RST_N = 1'b0; Load_Start = 1'b0; In_Valid = 1'b0; In_Data = '0; W = '0; J = '0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("rst_table_ready", int'(Table_Ready), 0);
    chk("rst_in_ready", int'(In_Ready), 0);
    chk("rst_lower_bound", int'(LowerBound), 0);
    chk("rst_load_count", int'(Load_Count), 0);

    // Table-driven full loads.
    for (int k = 0; k < 6; k++) begin
      fill(tbl[k].pat);
      pulse_start();
      feed(tbl[k].pct, 64);
      check_done(tbl[k].exp_lb < 0 ? model_lb() : tbl[k].exp_lb);
      if (tbl[k].pct == 100) chk("ready_cycles", ready_cycles, 64);
      sweep("cost_sweep");
    end

    // Restart mid-load; previous matrix is all zeros.
    for (int i = 0; i < 64; i++) prev[i] = mat[i];
    fill(4);
    pulse_start();
    feed(100, 20);
    chk("partial_count", int'(Load_Count), 20);
    @(negedge CLK);
    Load_Start = 1'b1;
    In_Valid   = 1'b1;
    In_Data    = 7'h7F;
    @(negedge CLK);
    Load_Start = 1'b0;
    In_Valid   = 1'b0;
    chk("restart_count", int'(Load_Count), 0);
    chk("restart_lb", int'(LowerBound), 0);
    W = 3'd2; J = 3'd4; #1;
    chk("restart_no_write", int'(Cost), int'(prev[20]));
    fill(4);
    feed(100, 64);
    check_done(model_lb());
    sweep("restart_sweep");

    // Reset after a complete load.
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    chk("rst2_table_ready", int'(Table_Ready), 0);
    chk("rst2_in_ready", int'(In_Ready), 0);
    chk("rst2_lower_bound", int'(LowerBound), 0);
    chk("rst2_load_count", int'(Load_Count), 0);

    // Writes attempted in READY are ignored.
    fill(0);
    pulse_start();
    feed(100, 64);
    check_done(268);
    In_Valid = 1'b1;
    In_Data  = 7'h55;
    repeat (4) @(negedge CLK);
    In_Valid = 1'b0;
    chk("ready_count_hold", int'(Load_Count), 64);
    chk("ready_still", int'(Table_Ready), 1);
    sweep("ready_no_write");

    // Reload from READY.
    @(negedge CLK);
    Load_Start = 1'b1;
    @(negedge CLK);
    Load_Start = 1'b0;
    chk("reload_tr_drop", int'(Table_Ready), 0);
    chk("reload_in_ready", int'(In_Ready), 1);
    chk("reload_count", int'(Load_Count), 0);
    chk("reload_lb", int'(LowerBound), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
